// File: rtl/dsram_fill_buf.sv
// Line fill buffer in front of the L1 data SRAM.
// Collects four 64-bit beats (critical beat first, 2-bit wrap), forwards the
// critical beat early, then writes the assembled 256-bit line in one cycle.
// Optional store-during-fill merging is built when DSRAM_FILL_STORE_MERGE_EN
// is defined; otherwise st_ready is tied low and the line is pure memory data.
module dsram_fill_buf #(
  parameter int ADDR_WIDTH = 13,
  parameter int BEAT_W     = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_index,
  input  logic [1:0]            req_cw,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [BEAT_W-1:0]     mem_data,
  output logic                  cw_valid,
  output logic [BEAT_W-1:0]     cw_data,
  input  logic                  st_valid,
  output logic                  st_ready,
  input  logic [2:0]            st_offset,
  input  logic [3:0]            st_be,
  input  logic [31:0]           st_wd,
  output logic [ADDR_WIDTH-1:0] ds_a,
  output logic [255:0]          ds_wd,
  output logic                  ds_write,
  output logic                  ds_fill,
  output logic [2:0]            ds_offset,
  output logic [3:0]            ds_be,
  output logic                  fill_done
);

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   idx_q;
  logic [1:0]              cw_q;
  logic [1:0]              cnt;
  logic [255:0]            line;
  logic [255:0]            line_nxt;
  logic [31:0]             held;     // bytes protected from beat data
  logic                    beat_acc;
  logic [1:0]              pos;

  assign req_ready = (state == IDLE);
  assign mem_ready = (state == FILL);
  assign beat_acc  = mem_valid && (state == FILL);
  assign pos       = cw_q + cnt;
  assign ds_offset = 3'd0;
  assign ds_be     = 4'hF;

`ifdef DSRAM_FILL_STORE_MERGE_EN
  logic [31:0] mask;
  logic [31:0] mask_nxt;
  logic [31:0] st_bmask;
  logic        st_acc;

  assign st_ready = (state == FILL);
  assign st_acc   = st_valid && (state == FILL);
  assign held     = mask;

  // Expand word offset + byte enables into a line-wide byte mask
  always_comb begin
    st_bmask = '0;
    for (int w = 0; w < 8; w++)
      if (st_offset == 3'(w)) st_bmask[w*4 +: 4] = st_be;
  end

  // Merge mask: cleared per request, accumulates accepted store bytes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          mask <= '0;
    else if (req_valid && state == IDLE) mask <= '0;
    else if (state == FILL)              mask <= mask_nxt;
  end
`else
  logic unused_st;

  assign st_ready  = 1'b0;
  assign held      = '0;
  assign unused_st = ^{st_valid, st_offset, st_be, st_wd};
`endif

  // Next line image: beat bytes land unless held; a same-cycle store wins
  always_comb begin
    line_nxt = line;
    for (int p = 0; p < 4; p++)
      for (int b = 0; b < 8; b++)
        if (beat_acc && pos == 2'(p) && !held[p*8+b])
          line_nxt[(p*8+b)*8 +: 8] = mem_data[b*8 +: 8];
`ifdef DSRAM_FILL_STORE_MERGE_EN
    mask_nxt = mask;
    if (st_acc) begin
      for (int i = 0; i < 32; i++)
        if (st_bmask[i]) line_nxt[i*8 +: 8] = st_wd[(i%4)*8 +: 8];
      mask_nxt = mask | st_bmask;
    end
`endif
  end

  // Fill FSM with registered SRAM strobes and critical-beat pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx_q     <= '0;
      cw_q      <= '0;
      cnt       <= '0;
      line      <= '0;
      cw_valid  <= 1'b0;
      cw_data   <= '0;
      ds_a      <= '0;
      ds_wd     <= '0;
      ds_write  <= 1'b0;
      ds_fill   <= 1'b0;
      fill_done <= 1'b0;
    end else begin
      cw_valid  <= 1'b0;
      ds_write  <= 1'b0;
      ds_fill   <= 1'b0;
      fill_done <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          idx_q <= req_index;
          cw_q  <= req_cw;
          cnt   <= '0;
          state <= FILL;
        end
        FILL: begin
          line <= line_nxt;
          if (beat_acc) begin
            cnt <= cnt + 2'd1;
            if (cnt == 2'd0) begin
              cw_valid <= 1'b1;
              cw_data  <= mem_data;
            end
            if (cnt == 2'd3) begin
              state     <= WRITE;
              ds_write  <= 1'b1;
              ds_fill   <= 1'b1;
              fill_done <= 1'b1;
              ds_a      <= idx_q;
              ds_wd     <= line_nxt;
            end
          end
        end
        WRITE:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dsram_fill_buf.sv
// Self-checking bench for dsram_fill_buf: table vectors, hand-written corner
// sequences and randomized fills checked against a byte-array line model.
module tb_dsram_fill_buf;

`ifdef DSRAM_FILL_STORE_MERGE_EN
  localparam bit MERGE = 1'b1;
`else
  localparam bit MERGE = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0, req_ready;
  logic [12:0]  req_index = '0;
  logic [1:0]   req_cw = '0;
  logic         mem_valid = 1'b0, mem_ready;
  logic [63:0]  mem_data = '0;
  logic         cw_valid;
  logic [63:0]  cw_data;
  logic         st_valid = 1'b0, st_ready;
  logic [2:0]   st_offset = '0;
  logic [3:0]   st_be = '0;
  logic [31:0]  st_wd = '0;
  logic [12:0]  ds_a;
  logic [255:0] ds_wd;
  logic         ds_write, ds_fill, fill_done;
  logic [2:0]   ds_offset;
  logic [3:0]   ds_be;

  always #5 clk = ~clk;

  dsram_fill_buf #(.ADDR_WIDTH(13), .BEAT_W(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_index(req_index), .req_cw(req_cw),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_data(mem_data),
    .cw_valid(cw_valid), .cw_data(cw_data),
    .st_valid(st_valid), .st_ready(st_ready), .st_offset(st_offset), .st_be(st_be), .st_wd(st_wd),
    .ds_a(ds_a), .ds_wd(ds_wd), .ds_write(ds_write), .ds_fill(ds_fill),
    .ds_offset(ds_offset), .ds_be(ds_be), .fill_done(fill_done)
  );

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int cw_cnt = 0;
  bit proto_bad = 1'b0;

  // Pulse counters and memory-side protocol watch, sampled at the active edge
  always @(posedge clk) begin
    if (ds_write) wr_cnt <= wr_cnt + 1;
    if (cw_valid) cw_cnt <= cw_cnt + 1;
    if (mem_valid && !mem_ready) proto_bad <= 1'b1;
  end

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Current fill plan (one optional store slot per beat)
  logic [12:0]  p_idx;
  logic [1:0]   p_cw;
  logic [63:0]  p_beat[4];
  int           p_gap[4];
  bit           p_sv[4];
  bit           p_same[4];
  logic [2:0]   p_off[4];
  logic [3:0]   p_be[4];
  logic [31:0]  p_wd[4];
  bit           p_keep;
  bit           p_st_all;
  logic [255:0] last_wd;

  task automatic clear_plan();
    for (int k = 0; k < 4; k++) begin
      p_gap[k] = 0; p_sv[k] = 0; p_same[k] = 0;
      p_off[k] = '0; p_be[k] = '0; p_wd[k] = '0; p_beat[k] = '0;
    end
    p_keep = 0; p_st_all = 0;
  endtask

  // Reference line: k-th arriving beat goes to slot (cw+k)%4, then stores
  // (in arrival order) overwrite their enabled bytes regardless of timing.
  function automatic logic [255:0] model();
    logic [7:0]   bytes[32];
    logic [255:0] r;
    int           slot;
    for (int k = 0; k < 4; k++) begin
      slot = (int'(p_cw) + k) % 4;
      for (int b = 0; b < 8; b++) bytes[slot*8+b] = p_beat[k][b*8 +: 8];
    end
    if (MERGE)
      for (int k = 0; k < 4; k++)
        if (p_sv[k])
          for (int b = 0; b < 4; b++)
            if (p_be[k][b]) bytes[int'(p_off[k])*4+b] = p_wd[k][b*8 +: 8];
    for (int i = 0; i < 32; i++) r[i*8 +: 8] = bytes[i];
    return r;
  endfunction

  task automatic fill_cyc_chk(input string nm);
    chk({nm, ".mem_ready"}, mem_ready, 1'b1);
    chk({nm, ".req_ready"}, req_ready, 1'b0);
    chk({nm, ".st_ready"}, st_ready, MERGE);
  endtask

  task automatic drive_store(input int k);
    st_valid = 1'b1; st_offset = p_off[k]; st_be = p_be[k]; st_wd = p_wd[k];
  endtask

  // Runs one fill from the plan; call and return at a negedge.
  task automatic run_fill(input string nm);
    int bound, cyc, exp_cyc, w0, c0;
    bound = 0;
    while (!req_ready && bound < 50) begin @(negedge clk); bound++; end
    chk({nm, ".req_wait"}, req_ready, 1'b1);
    req_valid = 1'b1; req_index = p_idx; req_cw = p_cw;
    w0 = wr_cnt; c0 = cw_cnt;
    exp_cyc = 5;
    @(negedge clk);
    cyc = 1;
    if (!p_keep) req_valid = 1'b0;
    chk({nm, ".accepted"}, mem_ready, 1'b1);
    st_valid = p_st_all;
    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < p_gap[k]; g++) begin
        fill_cyc_chk(nm);
        @(negedge clk); cyc++; exp_cyc++;
      end
      if (p_sv[k] && !p_same[k]) begin
        drive_store(k);
        fill_cyc_chk(nm);
        @(negedge clk); cyc++; exp_cyc++;
        st_valid = p_st_all;
      end
      if (p_sv[k] && p_same[k]) drive_store(k);
      mem_valid = 1'b1; mem_data = p_beat[k];
      fill_cyc_chk(nm);
      @(negedge clk); cyc++;
      mem_valid = 1'b0; st_valid = p_st_all;
      if (k == 0) begin
        chk({nm, ".cw_valid"}, cw_valid, 1'b1);
        chk({nm, ".cw_data"}, cw_data, p_beat[0]);
      end
    end
    st_valid = 1'b0;
    chk({nm, ".latency"}, 256'(cyc), 256'(exp_cyc));
    chk({nm, ".ds_write"}, ds_write, 1'b1);
    chk({nm, ".ds_fill"}, ds_fill, 1'b1);
    chk({nm, ".fill_done"}, fill_done, 1'b1);
    chk({nm, ".ds_a"}, ds_a, p_idx);
    chk({nm, ".ds_wd"}, ds_wd, model());
    chk({nm, ".write_mem_ready"}, mem_ready, 1'b0);
    chk({nm, ".write_req_ready"}, req_ready, 1'b0);
    last_wd = ds_wd;
    @(negedge clk);
    chk({nm, ".idle_req_ready"}, req_ready, 1'b1);
    chk({nm, ".idle_ds_write"}, ds_write, 1'b0);
    chk({nm, ".ds_a_hold"}, ds_a, p_idx);
    chk({nm, ".one_write"}, 256'(wr_cnt - w0), 256'd1);
    chk({nm, ".one_cw"}, 256'(cw_cnt - c0), 256'd1);
  endtask

  typedef struct {
    logic [12:0]  idx;
    logic [1:0]   cw;
    logic [63:0]  b0, b1, b2, b3;
    logic [255:0] exp;
  } vec_t;

  vec_t vt[4];

  initial begin
    int w0, c0;
    vt[0] = '{13'h1A5, 2'd0, 64'h0, 64'h1111111111111111, 64'h2222222222222222, 64'h3333333333333333,
              {64'h3333333333333333, 64'h2222222222222222, 64'h1111111111111111, 64'h0}};
    vt[1] = '{13'h0F0, 2'd2, 64'hAAAAAAAAAAAAAAAA, 64'hBBBBBBBBBBBBBBBB, 64'hCCCCCCCCCCCCCCCC, 64'hDDDDDDDDDDDDDDDD,
              {64'hBBBBBBBBBBBBBBBB, 64'hAAAAAAAAAAAAAAAA, 64'hDDDDDDDDDDDDDDDD, 64'hCCCCCCCCCCCCCCCC}};
    vt[2] = '{13'h1FFF, 2'd3, 64'h1, 64'h2, 64'h3, 64'h4, {64'h1, 64'h4, 64'h3, 64'h2}};
    vt[3] = '{13'h001, 2'd1, 64'hE0E0, 64'hF0F0, 64'h5050, 64'h6060, {64'h5050, 64'hF0F0, 64'hE0E0, 64'h6060}};

    // Reset held
    repeat (3) @(negedge clk);
    chk("rst.req_ready", req_ready, 1'b1);
    chk("rst.mem_ready", mem_ready, 1'b0);
    chk("rst.st_ready", st_ready, 1'b0);
    chk("rst.ds_write", ds_write, 1'b0);
    chk("rst.cw_valid", cw_valid, 1'b0);
    chk("rst.ds_wd", ds_wd, 256'd0);
    chk("rst.ds_be", ds_be, 4'hF);
    chk("rst.ds_offset", ds_offset, 3'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel.req_ready", req_ready, 1'b1);
    chk("rel.mem_ready", mem_ready, 1'b0);

    // Table vectors
    for (int i = 0; i < 4; i++) begin
      clear_plan();
      p_idx = vt[i].idx; p_cw = vt[i].cw;
      p_beat[0] = vt[i].b0; p_beat[1] = vt[i].b1; p_beat[2] = vt[i].b2; p_beat[3] = vt[i].b3;
      run_fill($sformatf("vec%0d", i));
      chk($sformatf("vec%0d.table", i), last_wd, vt[i].exp);
    end

    // Store merge into word 5 (or stores ignored when merge is not built)
    for (int s = 0; s < 2; s++) begin
      clear_plan();
      p_idx = 13'h0AB; p_cw = 2'd0;
      p_beat[0] = 64'h0; p_beat[1] = 64'h1111111111111111;
      p_beat[2] = 64'h2222222222222222; p_beat[3] = 64'h3333333333333333;
      p_sv[2] = 1; p_same[2] = (s == 1); p_off[2] = 3'd5; p_be[2] = 4'b0110; p_wd[2] = 32'hDEADBEEF;
      p_st_all = !MERGE;
      run_fill($sformatf("store%0d", s));
      chk($sformatf("store%0d.word5", s), last_wd[191:160], MERGE ? 32'h22ADBE22 : 32'h22222222);
    end

    // Gapped fill with a second request held high throughout
    clear_plan();
    p_idx = 13'h123; p_cw = 2'd1; p_keep = 1;
    for (int k = 0; k < 4; k++) begin p_gap[k] = (k == 0) ? 0 : 3; p_beat[k] = {$urandom, $urandom}; end
    run_fill("gap");
    clear_plan();
    p_idx = 13'h123; p_cw = 2'd1;
    for (int k = 0; k < 4; k++) p_beat[k] = 64'h0F0F_0000_0000_0000 | 64'(k);
    run_fill("held_req");

    // Reset in the middle of a fill after two beats
    req_valid = 1'b1; req_index = 13'h055; req_cw = 2'd0;
    @(negedge clk); req_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      mem_valid = 1'b1; mem_data = {$urandom, $urandom};
      @(negedge clk);
    end
    mem_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst.req_ready", req_ready, 1'b1);
    chk("midrst.mem_ready", mem_ready, 1'b0);
    chk("midrst.ds_a", ds_a, 13'd0);
    chk("midrst.cw_data", cw_data, 64'd0);
    @(negedge clk);
    w0 = wr_cnt; c0 = cw_cnt;
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("midrst.no_write", 256'(wr_cnt - w0), 256'd0);
    chk("midrst.no_cw", 256'(cw_cnt - c0), 256'd0);
    chk("midrst.idle", req_ready, 1'b1);

    // Randomized fills
    for (int n = 0; n < 30; n++) begin
      clear_plan();
      p_idx = 13'($urandom); p_cw = 2'($urandom);
      p_keep = ($urandom_range(0, 3) == 0);
      p_st_all = !MERGE && ($urandom_range(0, 1) == 1);
      for (int k = 0; k < 4; k++) begin
        p_beat[k] = {$urandom, $urandom};
        p_gap[k] = $urandom_range(0, 2);
        p_sv[k] = ($urandom_range(0, 2) == 0);
        p_same[k] = $urandom_range(0, 1) == 1;
        p_off[k] = 3'($urandom); p_be[k] = 4'($urandom); p_wd[k] = $urandom;
      end
      run_fill($sformatf("rnd%0d", n));
    end
    req_valid = 1'b0;
    repeat (3) @(negedge clk);

    chk("mem_protocol", proto_bad, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule

// File: doc/dsram_fill_buf.md
Name: dsram_fill_buf

Overview:
Line fill buffer directly upstream of the L1 data SRAM. Accepts a line-fill request and collects four 64-bit memory beats, delivered critical-beat-first with wrap. It forwards the critical beat early, assembles the 256-bit line, then issues a single full-line fill write into the data SRAM. One fill is in flight at a time.

Parameters:
ADDR_WIDTH, 13, SRAM line index width; must match the data SRAM.
BEAT_W, 64, memory beat width; fixed at 256/4, with 4 beats per line.

Ports:
clk  in  1  clock, all state on posedge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  fill request valid
req_ready  out  1  buffer idle; request accepted when valid&ready
req_index  in  ADDR_WIDTH  destination line index
req_cw  in  2  critical beat number (first beat returned by memory)
mem_valid  in  1  memory beat valid
mem_ready  out  1  buffer accepting beats
mem_data  in  64  beat data
cw_valid  out  1  one-cycle pulse: critical beat available
cw_data  out  64  critical beat data, held until next cw_valid
st_valid  in  1  store-during-fill valid
st_ready  out  1  store accepted when valid&ready
st_offset  in  3  32-bit word within line
st_be  in  4  byte enables within word
st_wd  in  32  store data
ds_a  out  ADDR_WIDTH  SRAM address
ds_wd  out  256  SRAM write data
ds_write  out  1  SRAM write strobe
ds_fill  out  1  marks write as line fill
ds_offset  out  3  tied 0
ds_be  out  4  tied 4'hF
fill_done  out  1  one-cycle pulse, coincident with ds_write

Behaviour:
- Line layout: beat k occupies ds_wd[64k+63:64k]. Word w occupies bits [32w+31:32w]. Byte b of word w occupies bit 32w+8b.
- Reset (async, rst_n=0): state IDLE. req_ready=1. mem_ready=0, st_ready=0, ds_write=0, ds_fill=0, fill_done=0, cw_valid=0. cw_data=0, ds_a=0, ds_wd=0, beat counter=0, merge mask=0.
- FSM has three states: IDLE, FILL, WRITE.
- IDLE: req_ready=1. On req_valid: latch req_index and req_cw, clear beat counter and merge mask, go to FILL.
- FILL: req_ready=0, mem_ready=1.
  - On each mem_valid, the beat lands at position (req_cw + cnt) mod 4 and cnt increments. Wrap is 2-bit modular, so req_cw=3 gives order 3,0,1,2.
  - Bytes whose merge-mask bit is set are not overwritten by beat data.
  - Gaps in mem_valid are allowed; state holds.
  - The first accepted beat (cnt==0) registers cw_data and pulses cw_valid on the next cycle.
  - On acceptance of the 4th beat, go to WRITE.
- WRITE (exactly one cycle):
  - ds_write=1, ds_fill=1, fill_done=1.
  - ds_a is the latched index; ds_wd is the assembled line.
  - mem_ready=0, req_ready=0. Next state is IDLE.
  - A new request is accepted one cycle later, so the minimum fill is 6 cycles request-to-request with no gaps.
- ds_write, ds_fill and fill_done are registered outputs, asserted only in WRITE.
- Outside WRITE, ds_a and ds_wd hold their last values.
- mem_valid in IDLE or WRITE is ignored. The memory side must not present beats then; the bench asserts on this.
- Reset mid-fill: the partial line is discarded, no SRAM write occurs, and no pulses are emitted after reset.

Optional Feature:
DSRAM_FILL_STORE_MERGE_EN.
- Defined:
  - st_ready=1 in FILL only, including the cycle the 4th beat is accepted.
  - An accepted store writes enabled bytes of st_wd into the line at st_offset and sets the matching merge-mask bits.
  - Later stores overwrite earlier ones.
  - If a store and a beat hit the same byte in the same cycle, the store wins.
  - Merged bytes survive subsequent beats.
- Undefined:
  - st_ready is tied 0 and the st_* inputs are ignored.
  - The merge mask and its logic are not built; the line is pure memory data.

Test Plan:
1. Reset held, then released → req_ready=1, mem_ready=0, ds_write=0. Assert rst_n mid-FILL after 2 beats → no ds_write, back to IDLE with req_ready=1.
2. req_index=0x1A5, req_cw=0, beats 0x0..0 through 0x3..3 back-to-back → exactly one ds_write 5 cycles after request acceptance. ds_wd={beat3,beat2,beat1,beat0}, ds_a=0x1A5, ds_fill=1, fill_done=1.
3. req_cw=2, beats A,B,C,D → A at beat 2, B at 3, C at 0, D at 1. cw_valid pulses once with cw_data=A.
4. mem_valid gaps of 3 idle cycles between beats, plus a second req_valid held high throughout → second request accepted only in the cycle after fill_done. The first line is correct.
5. (macro on) Store st_offset=5, st_be=4'b0110, st_wd=0xDEADBEEF before beat 2 arrives (req_cw=0) → final word 5 = {beat byte, 0xAD, 0xBE, beat byte}. Repeat with the store in the same cycle as beat 2 → same result.
6. (macro off) st_valid=1 throughout a fill → st_ready stays 0 and the line equals the memory data.
